rp_hv_assembler: RTL and testbench
==================================

// Module: rp_hv_assembler
// PURPOSE
//  Receiving end of the pruning segment stream: captures the SEQ_CYCLE_COUNT segments sequenced by the pruning FSM's
//  ctr select, checks their order and reassembles one pruned hypervector. Presents the result to the
//  bundling/compare datapath over a valid/ready handshake. Sits between the encoding MUX output and the class-HV/query logic.
// PARAMETERS
//  SEG_W            64   width of one pruned segment (bits)
//  SEQ_CYCLE_COUNT  4    segments per hypervector; must equal the FSM's sequence length, >=1
//  CTR_W            $clog2(SEQ_CYCLE_COUNT) (min 1)   width of seg_idx, matches FSM ctr width
//  DIM              SEG_W*SEQ_CYCLE_COUNT             assembled hypervector width
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  en         in   1       global enable; low = freeze (no capture, no state change, outputs held)
//  seg_valid  in   1       segment present this cycle
//  seg_idx    in   CTR_W   segment index (FSM ctr value)
//  seg_data   in   SEG_W   segment payload
//  seg_ready  out  1       segment accepted when seg_valid&&seg_ready&&en
//  hv_valid   out  1       assembled hypervector available
//  hv_ready   in   1       downstream accepts hv_data
//  hv_data    out  DIM     segment k occupies bits [k*SEG_W +: SEG_W]
//  seq_err    out  1       one-cycle pulse: out-of-order segment detected
//  busy       out  1       high in S_COLLECT
// BEHAVIOUR
//  Reset: state=S_IDLE, expected index=0, hv_valid=0, hv_data=0, seq_err=0, busy=0; seg_ready=1 after reset.
//  States (rp_pkg::asm_state_t): S_IDLE, S_COLLECT, S_HOLD.
//  S_IDLE: accept with idx==0 -> write slot 0, exp=1, go S_COLLECT (S_HOLD directly if SEQ_CYCLE_COUNT==1).
//    accept with idx!=0 -> drop, seq_err pulse next cycle, stay S_IDLE.
//  S_COLLECT: accept with idx==exp -> write slot exp, exp+=1; if exp was SEQ_CYCLE_COUNT-1 -> S_HOLD, exp=0.
//    accept with idx==0 -> seq_err, discard partial, restart: write slot 0, exp=1, stay S_COLLECT.
//    accept with any other idx -> seq_err, discard partial, exp=0, go S_IDLE.
//    no accept -> hold (gaps between segments allowed, no timeout).
//  S_HOLD: hv_valid=1, hv_data stable; seg_ready=hv_ready.
//    hv_valid&&hv_ready -> hv_valid falls next cycle; if a segment is accepted same cycle it is handled as in S_IDLE.
//  seg_ready = (state!=S_HOLD) || hv_ready; combinational, no path from seg_valid.
//  Latency: hv_valid rises the cycle after the last segment is accepted (1 clk).
//  Slots not yet rewritten are don't-care during S_COLLECT; hv_data only guaranteed while hv_valid=1.
//  seq_err registered, one cycle per offending segment; independent of hv handshake.
//  en low: no state/slot update, seq_err forced 0, hv_valid held; handshake completes only with en high.
//  Reset mid-collection: partial HV lost, hv_valid=0 immediately (async).
//  Index arithmetic in CTR_W bits; idx>=SEQ_CYCLE_COUNT (non-power-of-2 counts) always a sequence error.
// CONFIGURATION
//  RP_ASM_PARITY_EN defined: extra input seg_par (1 bit, even parity over seg_data); parity mismatch on an
//    accepted segment is treated exactly as an out-of-order segment (discard partial, S_IDLE) and additionally
//    pulses output par_err for one cycle. seq_err also pulses.
//  Not defined: no seg_par/par_err ports, no parity logic; all segments taken as correct.
// STRUCTURE
//  rp_pkg: asm_state_t enum, SEQ_CYCLE_COUNT default, ctr_w(n) function shared with the pruning FSM.
//  Sub-module rp_seg_bank: SEQ_CYCLE_COUNT x SEG_W register bank, one-hot write decode from (we, idx),
//    flat DIM-bit read port; no reset on data (reset values only for control).
//  Top: FSM, expected-index counter, handshake and error logic.
// TESTING (SEG_W=64, SEQ_CYCLE_COUNT=4 unless noted)
//  1. Idx 0..3 back-to-back, data 'hA0..'hA3, hv_ready=1 -> hv_valid 1 cycle after idx3, hv_data={A3,A2,A1,A0}.
//  2. Same with hv_ready=0 for 5 cycles then 1 -> seg_ready=0 while held, hv_data stable, single transfer.
//  3. Idx 0,1,3 -> seq_err pulse on idx3, state S_IDLE, no hv_valid; then 0..3 -> normal HV.
//  4. Idx 0,1,0,1,2,3 -> one seq_err, HV assembled from the second run only.
//  5. Handshake cycle with idx0 accepted concurrently, then 1..3 -> two HVs, no gap cycle, no seq_err.
//  6. rst asserted after idx1 -> hv_valid/busy 0 asynchronously; en low mid-sequence for 3 cycles -> no capture, resumes.

Source files
------------

// File: rtl/rp_pkg.sv
// Shared types and helpers for the random-projection pruning path (segment FSM and HV assembler).
package rp_pkg;

    localparam int unsigned DEF_SEG_W           = 64;
    localparam int unsigned DEF_SEQ_CYCLE_COUNT = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } asm_state_t;

    // Segment counter width; a single-segment sequence still needs a 1-bit index
    function automatic int unsigned ctr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rp_seg_bank.sv
// SEQ_CYCLE_COUNT x SEG_W segment register bank with one-hot write decode and a flat read port.
module rp_seg_bank
    import rp_pkg::*;
#(
    parameter int unsigned SEG_W           = DEF_SEG_W,
    parameter int unsigned SEQ_CYCLE_COUNT = DEF_SEQ_CYCLE_COUNT,
    parameter int unsigned CTR_W           = ctr_w(SEQ_CYCLE_COUNT),
    parameter int unsigned DIM             = SEG_W * SEQ_CYCLE_COUNT
) (
    input  logic             clk,
    input  logic             we,
    input  logic [CTR_W-1:0] idx,
    input  logic [SEG_W-1:0] wdata,
    output logic [DIM-1:0]   rdata
);

    logic [SEQ_CYCLE_COUNT-1:0] sel;
    logic [SEG_W-1:0]           slots [SEQ_CYCLE_COUNT];

    always_comb begin
        sel = '0;
        for (int unsigned k = 0; k < SEQ_CYCLE_COUNT; k++) begin
            sel[k] = we && (idx == CTR_W'(k));
        end
    end

    // Payload storage carries no reset; validity is tracked by the control FSM
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < SEQ_CYCLE_COUNT; k++) begin
            if (sel[k]) begin
                slots[k] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < SEQ_CYCLE_COUNT; k++) begin
            rdata[k*SEG_W +: SEG_W] = slots[k];
        end
    end

endmodule

// File: rtl/rp_hv_assembler.sv
// Reassembles ordered pruning segments into one hypervector with a valid/ready output.
// Optional segment parity checking is enabled by defining RP_ASM_PARITY_EN.
module rp_hv_assembler
    import rp_pkg::*;
#(
    parameter int unsigned SEG_W           = DEF_SEG_W,
    parameter int unsigned SEQ_CYCLE_COUNT = DEF_SEQ_CYCLE_COUNT,
    parameter int unsigned CTR_W           = ctr_w(SEQ_CYCLE_COUNT),
    parameter int unsigned DIM             = SEG_W * SEQ_CYCLE_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seg_valid,
    input  logic [CTR_W-1:0] seg_idx,
    input  logic [SEG_W-1:0] seg_data,
    output logic             seg_ready,
    output logic             hv_valid,
    input  logic             hv_ready,
    output logic [DIM-1:0]   hv_data,
    output logic             seq_err,
    output logic             busy
`ifdef RP_ASM_PARITY_EN
    ,
    input  logic             seg_par,
    output logic             par_err
`endif
);

    localparam logic [CTR_W-1:0] LAST_IDX    = CTR_W'(SEQ_CYCLE_COUNT - 1);
    localparam logic [CTR_W-1:0] START_EXP   = (SEQ_CYCLE_COUNT == 1) ? CTR_W'(0) : CTR_W'(1);
    localparam asm_state_t       START_STATE = (SEQ_CYCLE_COUNT == 1) ? S_HOLD : S_COLLECT;

    asm_state_t       state;
    logic [CTR_W-1:0] exp_idx;
    logic [DIM-1:0]   bank_data;
    logic             acc_c;
    logic             par_ok_c;
    logic             start_c;
    logic             match_c;
    logic             bad_c;

    assign seg_ready = (state != S_HOLD) || hv_ready;
    assign acc_c     = seg_valid && seg_ready && en;

`ifdef RP_ASM_PARITY_EN
    assign par_ok_c = ((^seg_data) == seg_par);
`else
    assign par_ok_c = 1'b1;
`endif

    // Index 0 always opens a fresh HV; in S_COLLECT exp_idx is never 0, so this is a restart there
    assign start_c = acc_c && par_ok_c && (seg_idx == '0);
    assign match_c = acc_c && par_ok_c && (state == S_COLLECT) && (seg_idx == exp_idx);
    assign bad_c   = acc_c && !start_c && !match_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            exp_idx <= '0;
            seq_err <= 1'b0;
`ifdef RP_ASM_PARITY_EN
            par_err <= 1'b0;
`endif
        end else if (!en) begin
            seq_err <= 1'b0;
`ifdef RP_ASM_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            seq_err <= bad_c || (start_c && (state == S_COLLECT));
`ifdef RP_ASM_PARITY_EN
            par_err <= acc_c && !par_ok_c;
`endif
            if (start_c) begin
                state   <= START_STATE;
                exp_idx <= START_EXP;
            end else if (match_c) begin
                if (exp_idx == LAST_IDX) begin
                    state   <= S_HOLD;
                    exp_idx <= '0;
                end else begin
                    exp_idx <= exp_idx + CTR_W'(1);
                end
            end else if (bad_c) begin
                state   <= S_IDLE;
                exp_idx <= '0;
            end else if ((state == S_HOLD) && hv_ready) begin
                state <= S_IDLE;
            end
        end
    end

    rp_seg_bank #(
        .SEG_W           (SEG_W),
        .SEQ_CYCLE_COUNT (SEQ_CYCLE_COUNT),
        .CTR_W           (CTR_W),
        .DIM             (DIM)
    ) u_bank (
        .clk   (clk),
        .we    (start_c || match_c),
        .idx   (seg_idx),
        .wdata (seg_data),
        .rdata (bank_data)
    );

    assign hv_valid = (state == S_HOLD);
    assign busy     = (state == S_COLLECT);
    assign hv_data  = hv_valid ? bank_data : '0;

endmodule

// File: tb/tb_rp_hv_assembler.sv
// Self-checking bench for rp_hv_assembler: scoreboard of expected HVs against observed transfers.
module tb_rp_hv_assembler;

    localparam int unsigned SEG_W = 64;
    localparam int unsigned SEQ   = 4;
    localparam int unsigned CTR_W = 2;
    localparam int unsigned DIM   = SEG_W * SEQ;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             seg_valid;
    logic [CTR_W-1:0] seg_idx;
    logic [SEG_W-1:0] seg_data;
    logic             seg_ready;
    logic             hv_valid;
    logic             hv_ready;
    logic [DIM-1:0]   hv_data;
    logic             seq_err;
    logic             busy;
`ifdef RP_ASM_PARITY_EN
    logic             seg_par;
    logic             par_err;
    assign seg_par = ^seg_data;
`endif

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int obs_rd = 0;
    logic [DIM-1:0] exp_q[$];
    logic [DIM-1:0] obs_q[$];

    rp_hv_assembler #(
        .SEG_W           (SEG_W),
        .SEQ_CYCLE_COUNT (SEQ),
        .CTR_W           (CTR_W),
        .DIM             (DIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seg_valid (seg_valid),
        .seg_idx   (seg_idx),
        .seg_data  (seg_data),
        .seg_ready (seg_ready),
        .hv_valid  (hv_valid),
        .hv_ready  (hv_ready),
        .hv_data   (hv_data),
        .seq_err   (seq_err),
        .busy      (busy)
`ifdef RP_ASM_PARITY_EN
        ,
        .seg_par   (seg_par),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    // Observe completed handshakes and error pulses mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (hv_valid && hv_ready && en) obs_q.push_back(hv_data);
            if (seq_err) err_cnt++;
        end
    end

    function automatic logic [DIM-1:0] mk_hv(input logic [63:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic send(input logic [CTR_W-1:0] idx, input logic [SEG_W-1:0] d);
        int n = 0;
        seg_valid = 1'b1;
        seg_idx   = idx;
        seg_data  = d;
        @(negedge clk);
        while (!(seg_ready && en) && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!(seg_ready && en)) begin
            fails++;
            $display("FAIL send_accept idx=%0d: seg_ready=%b en=%b, required accept within 50 cycles", idx, seg_ready, en);
        end
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((obs_q.size() - obs_rd) < exp_q.size() && n < 60) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if ((obs_q.size() - obs_rd) < exp_q.size()) begin
            fails++;
            $display("FAIL %s_timeout: observed %0d HVs, required %0d", name, obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            logic [DIM-1:0] e;
            e = exp_q.pop_front();
            tests++;
            if (obs_q[obs_rd] !== e) begin
                fails++;
                $display("FAIL %s_hv_data: got %h required %h", name, obs_q[obs_rd], e);
            end
            obs_rd++;
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs_q.size() != obs_rd) begin
            fails++;
            $display("FAIL %s_extra_xfer: %0d unexpected transfers, required 0", name, obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; seg_valid = 1'b0; seg_idx = '0; seg_data = '0; hv_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_bit("rst_hv_valid", hv_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_seq_err", seq_err, 1'b0);
        check_bit("rst_seg_ready", seg_ready, 1'b1);
        tests++;
        if (hv_data !== '0) begin
            fails++;
            $display("FAIL rst_hv_data: got %h required 0", hv_data);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
    endtask

    task automatic test_basic();
        exp_q.push_back(mk_hv(64'hA0, 64'hA1, 64'hA2, 64'hA3));
        for (int i = 0; i < 4; i++) send(CTR_W'(i), 64'hA0 + 64'(i));
        check_bit("basic_latency_hv_valid", hv_valid, 1'b1);
        drain("basic");
    endtask

    task automatic test_backpressure();
        logic [DIM-1:0] e;
        e = mk_hv(64'h11, 64'h22, 64'h33, 64'h44);
        hv_ready = 1'b0;
        exp_q.push_back(e);
        send(0, 64'h11); send(1, 64'h22); send(2, 64'h33); send(3, 64'h44);
        for (int c = 0; c < 5; c++) begin
            check_bit("bp_seg_ready", seg_ready, 1'b0);
            check_bit("bp_hv_valid", hv_valid, 1'b1);
            tests++;
            if (hv_data !== e) begin
                fails++;
                $display("FAIL bp_stable: got %h required %h", hv_data, e);
            end
            @(posedge clk);
            #1;
        end
        hv_ready = 1'b1;
        drain("bp");
    endtask

    task automatic test_out_of_order();
        int e0;
        e0 = err_cnt;
        send(2, 64'hDEAD);
        #1;
        check_bit("ooo_idle_seq_err", seq_err, 1'b1);
        check_bit("ooo_idle_busy", busy, 1'b0);
        send(0, 64'h1); send(1, 64'h2); send(3, 64'h4);
        check_bit("ooo_seq_err", seq_err, 1'b1);
        check_bit("ooo_busy", busy, 1'b0);
        check_bit("ooo_hv_valid", hv_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (err_cnt - e0 != 2) begin
            fails++;
            $display("FAIL ooo_err_count: got %0d required 2", err_cnt - e0);
        end
        exp_q.push_back(mk_hv(64'hC0, 64'hC1, 64'hC2, 64'hC3));
        for (int i = 0; i < 4; i++) send(CTR_W'(i), 64'hC0 + 64'(i));
        drain("ooo_recover");
    endtask

    task automatic test_restart();
        int e0;
        e0 = err_cnt;
        exp_q.push_back(mk_hv(64'hE0, 64'hE1, 64'hE2, 64'hE3));
        send(0, 64'hF0); send(1, 64'hF1);
        for (int i = 0; i < 4; i++) send(CTR_W'(i), 64'hE0 + 64'(i));
        drain("restart");
        tests++;
        if (err_cnt - e0 != 1) begin
            fails++;
            $display("FAIL restart_err_count: got %0d required 1", err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int e0;
        e0 = err_cnt;
        hv_ready = 1'b0;
        exp_q.push_back(mk_hv(64'hB0, 64'hB1, 64'hB2, 64'hB3));
        for (int i = 0; i < 4; i++) send(CTR_W'(i), 64'hB0 + 64'(i));
        exp_q.push_back(mk_hv(64'h70, 64'h71, 64'h72, 64'h73));
        hv_ready = 1'b1;
        send(0, 64'h70);
        check_bit("b2b_busy", busy, 1'b1);
        check_bit("b2b_hv_valid_low", hv_valid, 1'b0);
        for (int i = 1; i < 4; i++) send(CTR_W'(i), 64'h70 + 64'(i));
        check_bit("b2b_hv_valid", hv_valid, 1'b1);
        drain("b2b");
        tests++;
        if (err_cnt != e0) begin
            fails++;
            $display("FAIL b2b_err_count: got %0d required 0", err_cnt - e0);
        end
    endtask

    task automatic test_reset_and_enable();
        send(0, 64'h5); send(1, 64'h6);
        check_bit("rstmid_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_bit("rstmid_busy", busy, 1'b0);
        check_bit("rstmid_hv_valid", hv_valid, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        hv_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(CTR_W'(i), 64'h90 + 64'(i));
        check_bit("rsthold_hv_valid_before", hv_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_bit("rsthold_hv_valid", hv_valid, 1'b0);
        @(negedge clk) rst = 1'b0;
        hv_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk_hv(64'hD0, 64'hD1, 64'hD2, 64'hD3));
        send(0, 64'hD0); send(1, 64'hD1);
        en = 1'b0;
        seg_valid = 1'b1; seg_idx = '0; seg_data = 64'hBAD0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_bit("en_busy_held", busy, 1'b1);
            check_bit("en_seq_err", seq_err, 1'b0);
        end
        seg_valid = 1'b0;
        en = 1'b1;
        send(2, 64'hD2); send(3, 64'hD3);
        check_bit("en_hv_valid", hv_valid, 1'b1);
        drain("en_resume");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_out_of_order();
        test_restart();
        test_back_to_back();
        test_reset_and_enable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
